// File: rtl/fp_pkg.sv
// Shared definitions for the iterative single-precision divider.
// Holds the IEEE-754 field widths, the exponent bias and the saturated
// exponent code, plus the state encoding of the top-level controller.
package fp_pkg;

    localparam int         XLEN    = 32;
    localparam int         EXP_W   = 8;
    localparam int         MANT_W  = 23;
    localparam int         BIAS    = 127;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp_mant_div_core.sv
// Restoring mantissa divider: one quotient bit per cycle, MSB first.
// Produces q = floor({1,frac_a} * 2^24 / {1,frac_b}) as a 25-bit value.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears the control state)
//   start     load operands; iteration begins on the following cycle
//   frac_a    dividend fraction (hidden one added here)
//   frac_b    divisor fraction (hidden one added here)
//   done      high during the cycle whose closing edge writes the last bit
//   quot      25-bit quotient, complete after the edge that ends the done cycle
module fp_mant_div_core
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W-1:0] frac_a,
    input  logic [MANT_W-1:0] frac_b,
    output logic              done,
    output logic [MANT_W+1:0] quot
);

    localparam int ITER = MANT_W + 2;

    logic              active;
    logic [4:0]        cnt;
    logic [MANT_W+1:0] rem;
    logic [MANT_W:0]   dvsr;

    logic              ge;
    logic [MANT_W+1:0] rem_sel;

    // The remainder stays below twice the divisor, so 25 bits suffice.
    always_comb begin
        ge      = rem >= {1'b0, dvsr};
        rem_sel = ge ? (rem - {1'b0, dvsr}) : rem;
    end

    assign done = active && (cnt == 5'(ITER - 1));

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            cnt <= cnt + 5'd1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (start) begin
            rem  <= {2'b01, frac_a};
            dvsr <= {1'b1, frac_b};
        end else if (active) begin
            rem  <= rem_sel << 1;
            quot <= {quot[MANT_W:0], ge};
        end
    end

endmodule

// File: rtl/fp_iter_divider.sv
// Iterative IEEE-754 single-precision divider (truncating, subnormals
// flushed to zero). Special operands finish one cycle after acceptance;
// normal operands take 25 divide cycles, one normalise cycle and a done cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, aborts any operation
//   start        request; accepted only while busy is low
//   A, B         dividend and divisor, sampled on acceptance
//   busy         high from the cycle after acceptance through the done cycle
//   done         one-cycle pulse, result and div_by_zero valid
//   result       quotient, held until the next operation completes
//   div_by_zero  divisor exponent was zero; cleared on the next acceptance
module fp_iter_divider
    import fp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);

    state_t state, state_nxt;

    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [XLEN-1:0]    result_r;
    logic               dbz_r;

    logic [EXP_W-1:0]   ea, eb;
    logic               sgn, a_zero, b_zero, any_inf, special, accept;
    logic [XLEN-1:0]    special_res;
    logic               core_done;
    logic [MANT_W+1:0]  quot;

    // Saturate/flush the biased exponent and pack the truncated quotient.
    function automatic logic [31:0] pack_norm(input logic s,
                                              input logic signed [9:0] e,
                                              input logic [MANT_W+1:0] q);
        logic signed [9:0]  e_fin;
        logic [MANT_W-1:0]  m;
        e_fin = q[MANT_W+1] ? e : (e - 10'sd1);
        m     = q[MANT_W+1] ? q[MANT_W:1] : q[MANT_W-1:0];
        if (e_fin >= 10'sd255)
            pack_norm = {s, EXP_MAX, {MANT_W{1'b0}}};
        else if (e_fin <= 10'sd0)
            pack_norm = {s, 31'b0};
        else
            pack_norm = {s, e_fin[EXP_W-1:0], m};
    endfunction

    always_comb begin
        ea      = A[30:23];
        eb      = B[30:23];
        sgn     = A[31] ^ B[31];
        b_zero  = (eb == '0);
        a_zero  = (ea == '0);
        any_inf = (ea == EXP_MAX) || (eb == EXP_MAX);
        special = b_zero || a_zero || any_inf;
        accept  = (state == IDLE) && start;
        // Zero dividend wins over infinity unless the divisor is zero.
        special_res = (a_zero && !b_zero) ? {sgn, 31'b0}
                                          : {sgn, EXP_MAX, {MANT_W{1'b0}}};
    end

    fp_mant_div_core u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && !special),
        .frac_a (A[MANT_W-1:0]),
        .frac_b (B[MANT_W-1:0]),
        .done   (core_done),
        .quot   (quot)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = special ? DONE : DIVIDE;
            DIVIDE:  if (core_done) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and visible outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            result_r <= '0;
            dbz_r    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dbz_r <= b_zero;
                if (special) result_r <= special_res;
            end
            if (state == NORM) result_r <= pack_norm(sign_r, exp_r, quot);
        end
    end

    // Operand-derived sign and unnormalised exponent
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_r <= sgn;
            exp_r  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign result      = result_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_fp_iter_divider.sv
module tb_fp_iter_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] A, B;
    logic        busy, done, div_by_zero;
    logic [31:0] result;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_iter_divider #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Cycle 1 is the cycle right after the accepting edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int lat_req, input logic [31:0] res_req, input logic dbz_req);
        int guard = 0;
        int lat   = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(lat_req));
        chk({tag, " busy@done"}, {31'b0, busy}, 32'd1);
        chk({tag, " result"}, result, res_req);
        chk({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, dbz_req});
    endtask

    initial begin
        int lat;
        int saw_done;

        tbl[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27};
        tbl[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 27};
        tbl[2]  = '{32'hC1200000, 32'h40A00000, 32'hC0000000, 1'b0, 27};
        tbl[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1};
        tbl[4]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 27};
        tbl[5]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 27};
        tbl[6]  = '{32'h80000000, 32'h00000000, 32'hFF800000, 1'b1, 1};
        tbl[7]  = '{32'h00000000, 32'h40400000, 32'h00000000, 1'b0, 1};
        tbl[8]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1};
        tbl[9]  = '{32'h40000000, 32'hFF800000, 32'hFF800000, 1'b0, 1};
        tbl[10] = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 1'b0, 27};
        tbl[11] = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 1'b0, 27};
        tbl[12] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 27};
        tbl[13] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0, 27};
        tbl[14] = '{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 27};
        tbl[15] = '{32'h00800000, 32'h3FC00000, 32'h00000000, 1'b0, 27};
        tbl[16] = '{32'h00000000, 32'h7F800000, 32'h00000000, 1'b0, 1};

        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset div_by_zero", {31'b0, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].res, tbl[i].dbz);
        end

        // A second start while busy must not disturb the operation.
        @(negedge clk);
        A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 10) begin
                A = 32'h3F800000; B = 32'h00000000; start = 1'b1;
            end
            if (c == 11) start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
        chk("ignored-start latency", 32'(lat), 32'd27);
        chk("ignored-start result", result, 32'h40400000);
        chk("ignored-start div_by_zero", {31'b0, div_by_zero}, 32'd0);

        // Abort mid-operation with reset, then a fresh operation.
        @(negedge clk);
        @(negedge clk);
        A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        saw_done = 0;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            if (done) saw_done++;
            if (c == 10) start = 1'b1;
            if (c == 11) start = 1'b0;
            if (c == 15) begin
                rst = 1'b1; start = 1'b1;
                A = 32'h3F800000; B = 32'h00000000;
            end
            if (c == 16) begin
                chk("abort busy", {31'b0, busy}, 32'd0);
                chk("abort done", {31'b0, done}, 32'd0);
                chk("abort result", result, 32'd0);
                chk("abort div_by_zero", {31'b0, div_by_zero}, 32'd0);
                rst = 1'b0; start = 1'b0;
            end
        end
        chk("abort no done pulse", 32'(saw_done), 32'd0);
        run_op("post-abort", 32'h3F800000, 32'h40400000, 27, 32'h3EAAAAAA, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
